// File: rtl/spell_mem_router.sv
// spell_mem_router
// Registered request router and handshake controller for the SPELL core's
// memory path. A core request is latched, decoded to the internal memory or
// to the IO window (data space only), and the target select is held until
// that target answers or the access times out. Completion is reported with
// a one-cycle data_ready pulse and registered read data.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   select, addr, data_in,
//   memory_type_data, write  core request (select is a level)
//   data_out, data_ready     registered read data and completion pulse
//   busy                     high whenever the FSM is not idle
//   timeout_err              sticky timeout flag, cleared only by rst
//   mem_*                    internal-memory request / response
//   io_*                     IO request / response (io_addr is the window offset)

module spell_mem_router #(
   parameter int unsigned       ADDR_W  = 8,
   parameter int unsigned       DATA_W  = 8,
   parameter logic [ADDR_W-1:0] IO_BASE = 8'h20,
   parameter logic [ADDR_W-1:0] IO_SIZE = 8'h40,
   parameter int unsigned       TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              select,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              memory_type_data,
   input  logic              write,
   output logic [DATA_W-1:0] data_out,
   output logic              data_ready,
   output logic              busy,
   output logic              timeout_err,
   output logic              mem_select,
   output logic              mem_write,
   output logic              mem_type_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              io_select,
   output logic              io_write,
   output logic [ADDR_W-1:0] io_addr,
   output logic [DATA_W-1:0] io_wdata,
   input  logic [DATA_W-1:0] io_rdata,
   input  logic              io_ready
);

   // Counter only needs to reach TIMEOUT-1.
   localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int               LAST_I   = (TIMEOUT > 0) ? int'(TIMEOUT) - 1 : 0;
   localparam int               ONE_I    = 1;
   localparam logic [CNT_W-1:0] CNT_LAST = LAST_I[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_ONE  = ONE_I[CNT_W-1:0];
   localparam bit               TO_EN    = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_DONE    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             to_io_r;

   logic             decode_io_s;
   logic             tgt_ready_s;
   logic [DATA_W-1:0] tgt_rdata_s;

   // Window test done one bit wider than the address so BASE+SIZE cannot wrap.
   function automatic logic in_io_window(input logic [ADDR_W-1:0] a);
      logic [ADDR_W:0] a_x;
      logic [ADDR_W:0] lo_x;
      logic [ADDR_W:0] hi_x;
      a_x  = {1'b0, a};
      lo_x = {1'b0, IO_BASE};
      hi_x = lo_x + {1'b0, IO_SIZE};
      return (IO_SIZE != '0) && (a_x >= lo_x) && (a_x < hi_x);
   endfunction

   // Only data-space requests may reach the IO window.
   assign decode_io_s = memory_type_data & in_io_window(addr);
   assign tgt_ready_s = to_io_r ? io_ready : mem_ready;
   assign tgt_rdata_s = to_io_r ? io_rdata : mem_rdata;

   // Request FSM; every output is a register written here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         cnt_r         <= '0;
         to_io_r       <= 1'b0;
         data_out      <= '0;
         data_ready    <= 1'b0;
         busy          <= 1'b0;
         timeout_err   <= 1'b0;
         mem_select    <= 1'b0;
         mem_write     <= 1'b0;
         mem_type_data <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         io_select     <= 1'b0;
         io_write      <= 1'b0;
         io_addr       <= '0;
         io_wdata      <= '0;
      end else begin
         data_ready <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (select) begin
                  // Both targets see the latched request; only one gets select.
                  to_io_r       <= decode_io_s;
                  mem_select    <= ~decode_io_s;
                  io_select     <= decode_io_s;
                  mem_write     <= write;
                  mem_type_data <= memory_type_data;
                  mem_addr      <= addr;
                  mem_wdata     <= data_in;
                  io_write      <= write;
                  io_addr       <= addr - IO_BASE;
                  io_wdata      <= data_in;
                  cnt_r         <= '0;
                  busy          <= 1'b1;
                  state_r       <= ST_ACCESS;
               end else begin
                  busy <= 1'b0;
               end
            end
            ST_ACCESS: begin
               // Ready is checked first so it wins over a coincident timeout.
               if (tgt_ready_s) begin
                  if (!mem_write) begin
                     data_out <= tgt_rdata_s;
                  end else begin
                     data_out <= data_out;
                  end
                  mem_select <= 1'b0;
                  io_select  <= 1'b0;
                  data_ready <= 1'b1;
                  state_r    <= ST_DONE;
               end else if (TO_EN && (cnt_r == CNT_LAST)) begin
                  if (!mem_write) begin
                     data_out <= {DATA_W{1'b1}};
                  end else begin
                     data_out <= data_out;
                  end
                  mem_select  <= 1'b0;
                  io_select   <= 1'b0;
                  timeout_err <= 1'b1;
                  data_ready  <= 1'b1;
                  state_r     <= ST_DONE;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_DONE: begin
               if (select) begin
                  state_r <= ST_RELEASE;
               end else begin
                  busy    <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_RELEASE: begin
               // A held select is never treated as a new request.
               if (!select) begin
                  busy    <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_RELEASE;
               end
            end
            default: begin
               mem_select <= 1'b0;
               io_select  <= 1'b0;
               busy       <= 1'b0;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
